uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter BRCLOCK_CYCLES, default 10, giving clk cycles per serial bit (legal range >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: UART clock, all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port valid, input, 1 bit: din/pen/peven carry a byte to send.
REQ-005 The block SHALL have port din, input, 8 bits: byte to transmit, LSB first.
REQ-006 The block SHALL have port pen, input, 1 bit: parity bit enabled for this byte.
REQ-007 The block SHALL have port peven, input, 1 bit: 1 = even parity, 0 = odd parity.
REQ-008 The block SHALL have port ready, output, 1 bit: holding register empty, byte accepted when valid && ready.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: frame in progress on tx.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at end of each stop bit.

Function
REQ-012 The block SHALL hold a one-entry holding register (din, pen, peven, full flag); ready = !full while rst high, ready = 0 while rst low.
REQ-013 A handshake (valid && ready) SHALL capture din, pen and peven into the holding register; pen/peven are frame-local and sampled only at capture.
REQ-014 The FSM SHALL have states IDLE, START, DATA (bit index 0..7), PARITY, STOP.
REQ-015 In IDLE with holding full, the block SHALL move the entry to the shift register, clear full, enter START and assert busy on the next edge; tx falls on that same edge.
REQ-016 Handshake-to-tx-low latency from IDLE SHALL be exactly 2 clk cycles (capture edge, then load/START edge).
REQ-017 START, each DATA bit, PARITY and STOP SHALL each drive tx for exactly BRCLOCK_CYCLES cycles, timed by a bit counter that counts 0..BRCLOCK_CYCLES-1 and wraps.
REQ-018 START SHALL drive tx = 0; DATA SHALL drive din[0] first through din[7] last; STOP SHALL drive tx = 1.
REQ-019 PARITY SHALL be visited only if the frame's pen = 1, driving ^din for even and ~^din for odd.
REQ-020 Frame length SHALL be 10*BRCLOCK_CYCLES cycles without parity and 11*BRCLOCK_CYCLES cycles with parity.
REQ-021 On the last cycle of STOP, the block SHALL pulse done for one cycle.
REQ-022 On the last cycle of STOP with holding full, the block SHALL load the next byte and go directly to START, keeping busy high with zero idle cycles between frames.
REQ-023 On the last cycle of STOP with holding empty, the block SHALL return to IDLE, drop busy and leave tx = 1.
REQ-024 A new byte SHALL be accepted during a frame whenever the holding register is empty, including the load cycle itself, in which case the entry is not overwritten.
REQ-025 While full, valid SHALL be ignored and din SHALL NOT disturb the frame in progress or the held byte.
REQ-026 Illegal or unreachable FSM encodings SHALL return to IDLE with tx = 1.

Reset
REQ-027 While rst = 0 at a clock edge, the block SHALL set tx = 1, busy = 0, done = 0, ready = 0, state = IDLE, holding full = 0 and bit counter = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately and discard the held byte.
REQ-029 After reset deassertion, ready SHALL be 1 on the first cycle.

Verification
REQ-030 Bench SHALL check: BRCLOCK_CYCLES = 10, send 0xA5 with pen = 0 -> tx = 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, each held 10 cycles; done pulses at cycle 100 of the frame; busy drops afterwards.
REQ-031 Bench SHALL check: 0xA5 with pen = 1, peven = 1 -> parity bit 0, frame 110 cycles; with peven = 0 -> parity bit 1.
REQ-032 Bench SHALL check: 0x00 accepted, then 0xFF offered during frame 1 -> ready drops for 0xFF, both frames back-to-back with busy never low, done pulses twice 100 cycles apart.
REQ-033 Bench SHALL check: third byte 0x3C offered while first frame is active and holding is full -> ready = 0 and valid held high until ready rises; 0x3C is transmitted third, with no corruption of 0xFF.
REQ-034 Bench SHALL check: rst pulsed low during DATA bit 3 with holding full -> next cycle tx = 1, busy = 0, done = 0; no further frame is emitted; ready = 1 after release.
REQ-035 Bench SHALL check: BRCLOCK_CYCLES = 2, 0x81 with pen = 1, peven = 0 -> 22-cycle frame: bits 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Byte-wide UART transmitter with a one-entry holding register and an
//   optional per-frame parity bit. Frame: start(0), 8 data bits LSB first,
//   optional parity, stop(1). Each bit lasts BRCLOCK_CYCLES clk cycles.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   rst    : synchronous reset, active low
//   valid  : din/pen/peven carry a byte to send
//   din    : byte to transmit, LSB first
//   pen    : parity bit enabled for this byte
//   peven  : 1 = even parity, 0 = odd parity
//   ready  : holding register empty; byte accepted when valid && ready
//   tx     : serial line, idle high
//   busy   : frame in progress on tx
//   done   : one-cycle pulse on the last cycle of each stop bit
module uart_transmitter #(
   parameter int BRCLOCK_CYCLES = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic [7:0] din,
   input  logic       pen,
   input  logic       peven,
   output logic       ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CW = $clog2(BRCLOCK_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(BRCLOCK_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    data_q, data_d;
   logic          par_en_q, par_en_d;
   logic          par_even_q, par_even_d;
   logic [7:0]    hold_data_q, hold_data_d;
   logic          hold_pen_q, hold_pen_d;
   logic          hold_peven_q, hold_peven_d;
   logic          full_q, full_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          bit_end;
   logic          load;
   logic          accept;

   assign ready = rst & ~full_q;
   assign tx    = tx_q;
   assign busy  = busy_q;
   assign done  = done_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      data_d       = data_q;
      par_en_d     = par_en_q;
      par_even_d   = par_even_q;
      hold_data_d  = hold_data_q;
      hold_pen_d   = hold_pen_q;
      hold_peven_d = hold_peven_q;
      full_d       = full_q;
      load         = 1'b0;
      accept       = valid & rst & ~full_q;
      bit_end      = (cnt_q == CNT_LAST);
      cnt_d        = bit_end ? '0 : cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (full_q) load = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_end) begin
               if (full_q) load = 1'b1;
               else        state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // load only happens with the holding register full, so ready is low
      // and accept can never coincide with it
      if (load) begin
         state_d    = S_START;
         cnt_d      = '0;
         idx_d      = '0;
         data_d     = hold_data_q;
         par_en_d   = hold_pen_q;
         par_even_d = hold_peven_q;
         full_d     = 1'b0;
      end

      if (accept) begin
         hold_data_d  = din;
         hold_pen_d   = pen;
         hold_peven_d = peven;
         full_d       = 1'b1;
      end

      // outputs are registered from the next-state values so tx, busy and
      // done change on the same edge as the state they belong to
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[idx_d];
         S_PARITY: tx_d = par_even_d ? ^data_d : ~^data_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         data_q       <= '0;
         par_en_q     <= 1'b0;
         par_even_q   <= 1'b0;
         hold_data_q  <= '0;
         hold_pen_q   <= 1'b0;
         hold_peven_q <= 1'b0;
         full_q       <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         par_en_q     <= par_en_d;
         par_even_q   <= par_even_d;
         hold_data_q  <= hold_data_d;
         hold_pen_q   <= hold_pen_d;
         hold_peven_q <= hold_peven_d;
         full_q       <= full_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//   Directed bench for uart_transmitter: one instance with 10 clk/bit and
//   one with 2 clk/bit. Single frames come from a vector table; back-to-back
//   transfers and mid-frame reset are hand-written sequences.
module tb_uart_transmitter;

   logic       clk;
   logic       rst;
   logic       valid;
   logic [7:0] din;
   logic       pen;
   logic       peven;
   logic       sel;

   logic valid10, ready10, tx10, busy10, done10;
   logic valid2,  ready2,  tx2,  busy2,  done2;
   logic ready_m, tx_m, busy_m, done_m;
   int   nbit;

   int n_checks = 0;
   int n_fail   = 0;

   assign valid10 = valid & ~sel;
   assign valid2  = valid & sel;
   assign ready_m = sel ? ready2 : ready10;
   assign tx_m    = sel ? tx2    : tx10;
   assign busy_m  = sel ? busy2  : busy10;
   assign done_m  = sel ? done2  : done10;
   assign nbit    = sel ? 2 : 10;

   uart_transmitter #(.BRCLOCK_CYCLES(10)) dut10 (
      .clk(clk), .rst(rst), .valid(valid10), .din(din), .pen(pen), .peven(peven),
      .ready(ready10), .tx(tx10), .busy(busy10), .done(done10)
   );

   uart_transmitter #(.BRCLOCK_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .valid(valid2), .din(din), .pen(pen), .peven(peven),
      .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       sel;
      logic [7:0] data;
      logic       pen;
      logic       peven;
      logic [0:10] bits;   // line values in transmission order
      int         nbits;
   } vec_t;

   vec_t vecs[7];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!ready_m && n < 300) begin
         tick;
         n++;
      end
      check({name, "_ready_timeout"}, ready_m, 1'b1);
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int total;
      sel = v.sel;
      #1;
      wait_ready($sformatf("v%0d", i));
      valid = 1'b1;
      din   = v.data;
      pen   = v.pen;
      peven = v.peven;
      tick;
      valid = 1'b0;
      din   = 8'h00;
      pen   = 1'b0;
      peven = 1'b0;
      check($sformatf("v%0d_ready_after_capture", i), ready_m, 1'b0);
      check($sformatf("v%0d_tx_idle_before_start", i), tx_m, 1'b1);
      tick;
      total = v.nbits * nbit;
      for (int k = 0; k < total; k++) begin
         check($sformatf("v%0d_tx_k%0d", i, k), tx_m, v.bits[k / nbit]);
         check($sformatf("v%0d_busy_k%0d", i, k), busy_m, 1'b1);
         check($sformatf("v%0d_done_k%0d", i, k), done_m, (k == total - 1));
         tick;
      end
      check($sformatf("v%0d_busy_after", i), busy_m, 1'b0);
      check($sformatf("v%0d_tx_after", i), tx_m, 1'b1);
      check($sformatf("v%0d_done_after", i), done_m, 1'b0);
   endtask

   logic [0:9] f_bits[3];

   initial begin
      vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 11'b0_10100101_1_1, 10};
      vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b1, 11'b0_10100101_0_1, 11};
      vecs[2] = '{1'b0, 8'hA5, 1'b1, 1'b0, 11'b0_10100101_1_1, 11};
      vecs[3] = '{1'b0, 8'h01, 1'b1, 1'b0, 11'b0_10000000_0_1, 11};
      vecs[4] = '{1'b0, 8'hFF, 1'b1, 1'b1, 11'b0_11111111_0_1, 11};
      vecs[5] = '{1'b1, 8'h81, 1'b1, 1'b0, 11'b0_10000001_1_1, 11};
      vecs[6] = '{1'b1, 8'h3C, 1'b0, 1'b1, 11'b0_00111100_1_1, 10};
      f_bits[0] = 10'b0_00000000_1;
      f_bits[1] = 10'b0_11111111_1;
      f_bits[2] = 10'b0_00111100_1;

      rst = 1'b0; valid = 1'b0; din = 8'h00; pen = 1'b0; peven = 1'b0; sel = 1'b0;
      tick; tick; tick;
      check("rst_tx10", tx10, 1'b1);
      check("rst_busy10", busy10, 1'b0);
      check("rst_done10", done10, 1'b0);
      check("rst_ready10", ready10, 1'b0);
      check("rst_tx2", tx2, 1'b1);
      check("rst_busy2", busy2, 1'b0);
      check("rst_done2", done2, 1'b0);
      check("rst_ready2", ready2, 1'b0);
      rst = 1'b1;
      #1;
      check("release_ready10", ready10, 1'b1);
      check("release_ready2", ready2, 1'b1);
      tick;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // back-to-back: 0x00, then 0xFF, then 0x3C with valid held high
      sel = 1'b0;
      tick;
      fork
         begin : driver
            int n;
            valid = 1'b1;
            din   = 8'h00;
            pen   = 1'b0;
            check("b2b_ready_first", ready10, 1'b1);
            tick;
            din = 8'hFF;
            check("b2b_ready_drops_ff", ready10, 1'b0);
            n = 0;
            while (!ready10 && n < 300) begin tick; n++; end
            check("b2b_ff_wait", ready10, 1'b1);
            tick;
            din = 8'h3C;
            check("b2b_ready_drops_3c", ready10, 1'b0);
            n = 0;
            while (!ready10 && n < 300) begin
               check("b2b_valid_held", valid, 1'b1);
               tick;
               n++;
            end
            check("b2b_3c_wait", ready10, 1'b1);
            tick;
            valid = 1'b0;
            din   = 8'h00;
         end
         begin : monitor
            int m;
            m = 0;
            while (tx10 !== 1'b0 && m < 20) begin tick; m++; end
            check("b2b_start_timeout", tx10, 1'b0);
            for (int k = 0; k < 300; k++) begin
               check($sformatf("b2b_tx_k%0d", k), tx10, f_bits[k / 100][(k % 100) / 10]);
               check($sformatf("b2b_busy_k%0d", k), busy10, 1'b1);
               check($sformatf("b2b_done_k%0d", k), done10, ((k % 100) == 99));
               tick;
            end
            check("b2b_busy_after", busy10, 1'b0);
            check("b2b_tx_after", tx10, 1'b1);
         end
      join
      tick;

      // reset during data bit 3 with the holding register full
      valid = 1'b1;
      din   = 8'hA5;
      pen   = 1'b0;
      wait_ready("rstmid_first");
      tick;
      din = 8'h55;
      wait_ready("rstmid_second");
      tick;
      valid = 1'b0;
      din   = 8'h00;
      check("rstmid_hold_full", ready10, 1'b0);
      repeat (41) tick;
      check("rstmid_in_bit3", tx10, 1'b0);
      check("rstmid_busy_before", busy10, 1'b1);
      rst = 1'b0;
      tick;
      check("rstmid_tx", tx10, 1'b1);
      check("rstmid_busy", busy10, 1'b0);
      check("rstmid_done", done10, 1'b0);
      check("rstmid_ready_low", ready10, 1'b0);
      rst = 1'b1;
      #1;
      check("rstmid_ready_release", ready10, 1'b1);
      for (int k = 0; k < 150; k++) begin
         tick;
         check($sformatf("rstmid_quiet_tx_k%0d", k), tx10, 1'b1);
         check($sformatf("rstmid_quiet_busy_k%0d", k), busy10, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
